mmio_uart_tx: RTL and testbench

- Memory-mapped UART transmitter on the CPU data-memory bus, downstream of the ALU/store path.
- Shares the address, store-data and store-width signals that drive data memory. It claims a small address window and serialises stored bytes onto a TX pin (8N1, LSB first).
- A small FIFO decouples single-cycle stores from the much slower serial line.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/mmio_uart_tx_if.sv | 21 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/mmio_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions used by the memory-mapped UART transmitter:
// store/load encodings, register offsets, STATUS bit layout and FSM states.
package cpu_pkg;

    // Store width on the data-memory bus
    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    // Load type value meaning "no load"
    localparam logic [2:0] MR_NONE = 3'b000;

    // Word offsets (address[3:2]) inside the UART window
    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_DIV    = 2'd2;
    localparam logic [1:0] UART_RSVD   = 2'd3;

    // STATUS register bit positions
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;
    localparam int STAT_COUNT = 4;

    // Serialiser states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus signals shared between the CPU store/load path and the UART.
interface mmio_uart_tx_if;

    logic [31:0] address;
    logic [31:0] write_data;
    logic [1:0]  MemWrite;
    logic [2:0]  MemRead;
    logic [31:0] rdata;
    logic        sel;

    modport master (
        output address, write_data, MemWrite, MemRead,
        input  rdata, sel
    );

    modport slave (
        input  address, write_data, MemWrite, MemRead,
        output rdata, sel
    );

endinterface

// File: rtl/sync_fifo.sv
// Small circular FIFO; the caller only pushes when there is room (or a pop
// lands on the same edge) and only pops when it is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Entry storage; contents need no reset because count gates validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter sitting beside data memory. Stores to
// TXDATA are queued in a FIFO and shifted out LSB first on a registered tx.
module mmio_uart_tx
    import cpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
    input  logic            clk,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    offset;
    logic          sel;
    logic          is_load;
    logic          is_store;
    logic          enq_req;
    logic          div_wr;
    logic          stat_rd;
    logic          overflow_evt;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_rdata;
    logic [15:0]   div_reg;
    logic [15:0]   eff_div;
    logic [15:0]   baud_reload;
    logic          overflow;
    uart_state_t   state;
    logic [7:0]    shift;
    logic [2:0]    bitcnt;
    logic [15:0]   baud;
    logic [31:0]   count_ext;
    logic [31:0]   status;
    logic [31:0]   rdata_mux;
    logic          unused_bits;

    assign sel      = (bus.address[31:4] == BASE_ADDR[31:4]);
    assign offset   = bus.address[3:2];
    assign is_load  = (bus.MemRead != MR_NONE);
    assign is_store = (bus.MemWrite != MW_NONE);
    assign enq_req  = sel && is_store && (offset == UART_TXDATA);
    assign div_wr   = sel && is_store && (offset == UART_DIV);
    assign stat_rd  = sel && is_load && (offset == UART_STATUS);

    // The serialiser drains the FIFO only from IDLE, so a pop can free the
    // slot that a store to a full FIFO needs on the same edge.
    assign fifo_pop     = (state == IDLE) && !fifo_empty;
    assign fifo_push    = enq_req && (!fifo_full || fifo_pop);
    assign overflow_evt = enq_req && fifo_full && !fifo_pop;

    assign eff_div     = (div_reg == 16'd0) ? 16'd1 : div_reg;
    assign baud_reload = eff_div - 16'd1;

    assign unused_bits = ^{bus.address[1:0], bus.write_data[31:16]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.write_data[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Divisor register: byte stores touch the low byte only
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg <= DEFAULT_DIV;
        end else if (div_wr) begin
            if (bus.MemWrite == MW_BYTE) begin
                div_reg[7:0] <= bus.write_data[7:0];
            end else begin
                div_reg <= bus.write_data[15:0];
            end
        end
    end

    // Sticky overflow flag, cleared by a STATUS read; a new drop wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (overflow_evt) begin
            overflow <= 1'b1;
        end else if (stat_rd) begin
            overflow <= 1'b0;
        end
    end

    // Serialiser: tx is set alongside each state change so it never glitches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            tx     <= 1'b1;
            shift  <= 8'd0;
            bitcnt <= 3'd0;
            baud   <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift  <= fifo_rdata;
                        bitcnt <= 3'd0;
                        baud   <= baud_reload;
                        state  <= START;
                        tx     <= 1'b0;
                    end
                end
                START: begin
                    if (baud == 16'd0) begin
                        baud  <= baud_reload;
                        state <= DATA;
                        tx    <= shift[0];
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                DATA: begin
                    if (baud == 16'd0) begin
                        shift  <= {1'b0, shift[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        baud   <= baud_reload;
                        if (bitcnt == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            tx <= shift[1];
                        end
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud == 16'd0) begin
                        state <= IDLE;
                    end else begin
                        baud <= baud - 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign count_ext = 32'(fifo_count);

    // STATUS word assembled from live FIFO/FSM state
    always_comb begin
        status                      = '0;
        status[STAT_FULL]           = fifo_full;
        status[STAT_EMPTY]          = fifo_empty;
        status[STAT_BUSY]           = (state != IDLE);
        status[STAT_OVF]            = overflow;
        status[STAT_COUNT +: 3]     = count_ext[2:0];
    end

    // Read mux; unselected or non-load cycles return zero
    always_comb begin
        rdata_mux = '0;
        if (sel && is_load) begin
            case (offset)
                UART_STATUS: rdata_mux = status;
                UART_DIV:    rdata_mux = {16'd0, div_reg};
                default:     rdata_mux = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_mux;
    assign bus.sel   = sel;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a register-access vector table, a
// frame-decoding monitor fed by a scoreboard queue, and hand-timed sequences
// for frame timing, FIFO overflow, reset and mid-frame divisor changes.
module tb_mmio_uart_tx;
    import cpu_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_ST = 32'h1000_0004;
    localparam logic [31:0] A_DV = 32'h1000_0008;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  mw;
        logic [2:0]  mr;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    logic clk;
    logic reset;
    logic tx;

    int checks;
    int errors;

    logic [7:0] sb[$];
    int         mon_div;
    logic       mon_en;
    logic       mon_busy;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (4),
        .DEFAULT_DIV (16'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop so a stuck design cannot hang the run
    initial begin
        #500_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx <= 0) return 1'b0;
        if (idx >= 9) return 1'b1;
        return b[idx-1];
    endfunction

    task automatic bus_idle();
        bus.address    = 32'd0;
        bus.write_data = 32'd0;
        bus.MemWrite   = MW_NONE;
        bus.MemRead    = MR_NONE;
    endtask

    // One bus cycle: drive now (just after an edge), sample mid-cycle, then
    // let the next rising edge commit it
    task automatic apply_stimulus(input vec_t v, input int idx);
        bus.address    = v.addr;
        bus.write_data = v.wdata;
        bus.MemWrite   = v.mw;
        bus.MemRead    = v.mr;
        @(negedge clk);
        check_output($sformatf("vec%0d_sel", idx), {31'd0, bus.sel}, {31'd0, v.exp_sel});
        if (v.mr != MR_NONE)
            check_output($sformatf("vec%0d_rdata", idx), bus.rdata, v.exp_rdata);
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mw);
        bus.address    = addr;
        bus.write_data = data;
        bus.MemWrite   = mw;
        bus.MemRead    = MR_NONE;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic bus_read(input logic [31:0] addr, input string name, input logic [31:0] expected);
        bus.address = addr;
        bus.MemRead = 3'b010;
        @(negedge clk);
        check_output(name, bus.rdata, expected);
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    // Wait (bounded) for the scoreboard to drain and the line to settle
    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0 && !mon_busy) break;
            @(posedge clk);
        end
        repeat (2 * mon_div + 2) @(posedge clk);
        #1;
        check_output("drain_scoreboard", sb.size(), 0);
    endtask

    // Frame monitor: samples each bit half a cycle after it starts and
    // compares the received byte with the scoreboard head
    initial begin
        logic [7:0] rx;
        int         d;
        mon_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && tx == 1'b0) begin
                mon_busy = 1'b1;
                d  = mon_div;
                rx = 8'd0;
                for (int b = 0; b < 8; b++) begin
                    repeat (d) @(negedge clk);
                    rx[b] = tx;
                end
                repeat (d) @(negedge clk);
                check_output("frame_stop", {31'd0, tx}, 32'd1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL frame_unexpected: got 0x%02h expected no frame", rx);
                end else begin
                    check_output("frame_data", {24'd0, rx}, {24'd0, sb.pop_front()});
                end
                mon_busy = 1'b0;
            end
        end
    end

    vec_t vecs[19];

    initial begin
        logic [7:0] b;
        checks  = 0;
        errors  = 0;
        mon_en  = 1'b0;
        mon_div = 16;
        reset   = 1'b1;
        bus_idle();

        // Register-access table, run with DIV=16 and an idle, empty block
        vecs[0]  = '{addr:A_ST,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h02};
        vecs[1]  = '{addr:A_DV,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h10};
        vecs[2]  = '{addr:A_TX,          wdata:32'd0,          mw:MW_NONE, mr:3'b100, exp_sel:1'b1, exp_rdata:32'h0};
        vecs[3]  = '{addr:32'h1000_000C, wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h0};
        vecs[4]  = '{addr:32'h1000_0007, wdata:32'd0,          mw:MW_NONE, mr:3'b001, exp_sel:1'b1, exp_rdata:32'h02};
        vecs[5]  = '{addr:A_DV,          wdata:32'h1234_56AB,  mw:MW_BYTE, mr:MR_NONE, exp_sel:1'b1, exp_rdata:32'h0};
        vecs[6]  = '{addr:A_DV,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h00AB};
        vecs[7]  = '{addr:A_DV,          wdata:32'hFFFF_1234,  mw:MW_HALF, mr:MR_NONE, exp_sel:1'b1, exp_rdata:32'h0};
        vecs[8]  = '{addr:A_DV,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h1234};
        vecs[9]  = '{addr:32'h1000_000C, wdata:32'hFFFF_FFFF,  mw:MW_WORD, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h0};
        vecs[10] = '{addr:A_DV,          wdata:32'hABCD_0010,  mw:MW_WORD, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h1234};
        vecs[11] = '{addr:A_DV,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h0010};
        vecs[12] = '{addr:32'h1000_0010, wdata:32'h0000_0077,  mw:MW_BYTE, mr:MR_NONE, exp_sel:1'b0, exp_rdata:32'h0};
        vecs[13] = '{addr:32'h0FFF_FFFC, wdata:32'd0,          mw:MW_NONE, mr:3'b001, exp_sel:1'b0, exp_rdata:32'h0};
        vecs[14] = '{addr:32'h0FFF_FFFC, wdata:32'h0000_0099,  mw:MW_WORD, mr:3'b010, exp_sel:1'b0, exp_rdata:32'h0};
        vecs[15] = '{addr:A_ST,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h02};
        vecs[16] = '{addr:A_ST,          wdata:32'h0000_FFFF,  mw:MW_WORD, mr:MR_NONE, exp_sel:1'b1, exp_rdata:32'h0};
        vecs[17] = '{addr:A_ST,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h02};
        vecs[18] = '{addr:A_DV,          wdata:32'd0,          mw:MW_NONE, mr:3'b010, exp_sel:1'b1, exp_rdata:32'h0010};

        // Power-on reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset_tx", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        bus_read(A_ST, "reset_status", 32'h02);

        for (int i = 0; i < 19; i++) begin
            apply_stimulus(vecs[i], i);
        end

        // 0x55 at DIV=16: exact bit timing plus busy during the frame
        $display("[TB] frame 0x55 at div 16");
        mon_div = 16;
        b = 8'h55;
        sb.push_back(b);
        bus_write(A_TX, 32'h55, MW_BYTE);
        @(negedge clk);
        check_output("a_prestart_tx", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        for (int n = 0; n < 160; n++) begin
            @(negedge clk);
            check_output($sformatf("a_bit%0d_cyc%0d", n / 16, n % 16), {31'd0, tx}, {31'd0, frame_bit(b, n / 16)});
            if (n == 40) check_output("a_status_busy", bus.rdata, 32'h06);
            @(posedge clk);
            #1;
            if (n == 39) begin
                bus.address = A_ST;
                bus.MemRead = 3'b010;
            end
            if (n == 40) bus_idle();
        end
        bus_read(A_ST, "a_status_after", 32'h02);
        wait_idle(400);

        // DIV=0 behaves as 1: single-cycle bits and back-to-back spacing
        $display("[TB] div 0 frames");
        bus_write(A_DV, 32'd0, MW_WORD);
        mon_div = 1;
        b = 8'hA3;
        sb.push_back(b);
        bus_write(A_TX, 32'hA3, MW_BYTE);
        @(negedge clk);
        check_output("b_prestart_tx", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check_output($sformatf("b_a3_bit%0d", n), {31'd0, tx}, {31'd0, frame_bit(b, n)});
            @(posedge clk);
            #1;
        end
        sb.push_back(8'h3C);
        sb.push_back(8'hC3);
        bus_write(A_TX, 32'h3C, MW_BYTE);
        bus_write(A_TX, 32'hC3, MW_BYTE);
        for (int n = 0; n < 21; n++) begin
            logic e;
            if (n < 10)       e = frame_bit(8'h3C, n);
            else if (n == 10) e = 1'b1;
            else              e = frame_bit(8'hC3, n - 11);
            @(negedge clk);
            check_output($sformatf("b_b2b_cyc%0d", n), {31'd0, tx}, {31'd0, e});
            @(posedge clk);
            #1;
        end
        wait_idle(100);

        // Overflow: DIV=100, six stores on consecutive edges
        $display("[TB] overflow at div 100");
        bus_write(A_DV, 32'd100, MW_WORD);
        mon_div = 100;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d8;
            d8 = 8'(8'h11 * (i + 1));
            if (i < 5) sb.push_back(d8);
            bus_write(A_TX, {24'd0, d8}, MW_BYTE);
        end
        bus_read(A_ST, "c_status_ovf", 32'h4D);
        bus_read(A_ST, "c_status_cleared", 32'h45);
        wait_idle(6000);

        // Full FIFO: enqueue lands on the same edge as the serialiser pop
        $display("[TB] push on pop edge with full fifo");
        bus_write(A_DV, 32'd2, MW_WORD);
        mon_div = 2;
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d8;
            d8 = 8'(8'hA1 + i);
            sb.push_back(d8);
            bus_write(A_TX, {24'd0, d8}, MW_BYTE);
        end
        repeat (17) @(posedge clk);
        #1;
        sb.push_back(8'hA6);
        bus_write(A_TX, 32'hA6, MW_BYTE);
        bus_read(A_ST, "d_status_full_no_ovf", 32'h45);
        wait_idle(400);

        // Asynchronous reset in the middle of a data bit
        $display("[TB] reset mid frame");
        mon_en = 1'b0;
        bus_write(A_DV, 32'd4, MW_WORD);
        bus_write(A_TX, 32'h00, MW_BYTE);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_output("e_tx_in_data", {31'd0, tx}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_output("e_tx_async", {31'd0, tx}, 32'd1);
        bus.address = A_ST;
        bus.MemRead = 3'b010;
        #1;
        check_output("e_status_async", bus.rdata, 32'h02);
        @(posedge clk);
        #1;
        bus.address = A_DV;
        #1;
        check_output("e_div_reset", bus.rdata, 32'h10);
        @(negedge clk);
        check_output("e_tx_held", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_idle();
        repeat (2) @(posedge clk);
        #1;
        mon_div = 16;
        mon_en  = 1'b1;
        sb.push_back(8'h96);
        bus_write(A_TX, 32'h96, MW_BYTE);
        wait_idle(400);

        // DIV=8 written during the start bit applies from the next bit
        $display("[TB] div change mid frame");
        mon_en = 1'b0;
        b = 8'hB4;
        bus_write(A_TX, 32'hB4, MW_BYTE);
        @(negedge clk);
        check_output("f_prestart_tx", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        for (int n = 0; n < 88; n++) begin
            int idx;
            idx = (n < 16) ? 0 : 1 + (n - 16) / 8;
            @(negedge clk);
            check_output($sformatf("f_cyc%0d", n), {31'd0, tx}, {31'd0, frame_bit(b, idx)});
            @(posedge clk);
            #1;
            if (n == 3) begin
                bus.address    = A_DV;
                bus.write_data = 32'd8;
                bus.MemWrite   = MW_WORD;
            end
            if (n == 4) bus_idle();
        end
        mon_div = 8;
        mon_en  = 1'b1;
        sb.push_back(8'h5A);
        bus_write(A_TX, 32'h5A, MW_BYTE);
        wait_idle(300);
        bus_read(A_ST, "final_status", 32'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
